// File: rtl/pipeline_ctrl.sv
// ============================================================================
// Module      : pipeline_ctrl
// Description : Stall/flush sequencer for the six-stage pipeline, with
//               saturating stall-cycle and flush counters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipeline_ctrl #(
    parameter int                    ADDR_WIDTH      = 32,
    parameter logic [ADDR_WIDTH-1:0] EXC_VECTOR      = 32'hBFC00380,
    parameter int                    STALL_CNT_WIDTH = 32,
    parameter int                    FLUSH_CNT_WIDTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       stall_req_if,
    input  logic                       stall_req_id,
    input  logic                       stall_req_ex,
    input  logic                       stall_req_mem,
    input  logic                       exc_valid,
    input  logic                       exc_is_eret,
    input  logic [ADDR_WIDTH-1:0]      cp0_epc,
    input  logic                       cnt_clr,
    output logic [5:0]                 stall,
    output logic                       flush,
    output logic [ADDR_WIDTH-1:0]      redirect_pc,
    output logic [STALL_CNT_WIDTH-1:0] stall_cnt,
    output logic [FLUSH_CNT_WIDTH-1:0] flush_cnt
);

    localparam logic [1:0] ST_RUN      = 2'd0;
    localparam logic [1:0] ST_EXC_WAIT = 2'd1;
    localparam logic [1:0] ST_FLUSH    = 2'd2;

    localparam logic [5:0] c_stall_all = 6'b111111;
    localparam logic [STALL_CNT_WIDTH-1:0] c_stall_one = {{(STALL_CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [FLUSH_CNT_WIDTH-1:0] c_flush_one = {{(FLUSH_CNT_WIDTH-1){1'b0}}, 1'b1};

    logic [1:0]                 r_state;
    logic [1:0]                 w_state_next;
    logic                       r_eret;
    logic [ADDR_WIDTH-1:0]      r_epc;
    logic [STALL_CNT_WIDTH-1:0] r_stall_cnt;
    logic [FLUSH_CNT_WIDTH-1:0] r_flush_cnt;
    logic [5:0]                 w_stall_dec;
    logic [5:0]                 w_stall;
    logic                       w_flush;
    logic                       w_bus_busy;

    assign w_bus_busy = stall_req_if | stall_req_mem;

    // Highest stalled stage wins; the stage below it gets a bubble.
    always_comb begin
        w_stall_dec = 6'b000000;
        if (stall_req_mem)     w_stall_dec = 6'b011111;
        else if (stall_req_ex) w_stall_dec = 6'b001111;
        else if (stall_req_id) w_stall_dec = 6'b000111;
        else if (stall_req_if) w_stall_dec = 6'b000011;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= ST_RUN;
        else      r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_RUN: begin
                if (exc_valid) w_state_next = w_bus_busy ? ST_EXC_WAIT : ST_FLUSH;
            end
            ST_EXC_WAIT: begin
                if (!w_bus_busy) w_state_next = ST_FLUSH;
            end
            ST_FLUSH: w_state_next = ST_RUN;
            default:  w_state_next = ST_RUN;
        endcase
    end

    always_comb begin
        w_stall = 6'b000000;
        w_flush = 1'b0;
        case (r_state)
            ST_RUN:      w_stall = exc_valid ? c_stall_all : w_stall_dec;
            ST_EXC_WAIT: w_stall = c_stall_all;
            ST_FLUSH:    w_flush = 1'b1;
            default:     w_stall = 6'b000000;
        endcase
    end

    // Request inputs feed stall directly, so reset must mask them too.
    assign stall = rst ? w_stall : 6'b000000;
    assign flush = w_flush;
    assign redirect_pc = w_flush ? (r_eret ? r_epc : EXC_VECTOR) : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_eret <= 1'b0;
            r_epc  <= '0;
        end else if (r_state == ST_RUN && exc_valid) begin
            r_eret <= exc_is_eret;
            r_epc  <= cp0_epc;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else if (cnt_clr) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_stall != 6'b000000 && !(&r_stall_cnt))
                r_stall_cnt <= r_stall_cnt + c_stall_one;
            if (w_flush && !(&r_flush_cnt))
                r_flush_cnt <= r_flush_cnt + c_flush_one;
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;

endmodule

`default_nettype wire

// File: tb/tb_pipeline_ctrl.sv
// ============================================================================
// Module      : tb_pipeline_ctrl
// Description : Directed self-checking bench for pipeline_ctrl, including a
//               narrow-counter instance for saturation behaviour.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pipeline_ctrl;

    logic        clk;
    logic        rst;
    logic        stall_req_if, stall_req_id, stall_req_ex, stall_req_mem;
    logic        exc_valid, exc_is_eret, cnt_clr;
    logic [31:0] cp0_epc;
    logic [5:0]  stall, stall_s;
    logic        flush, flush_s;
    logic [31:0] redirect_pc, redirect_pc_s;
    logic [31:0] stall_cnt;
    logic [15:0] flush_cnt;
    logic [3:0]  stall_cnt_s;
    logic [1:0]  flush_cnt_s;

    int n_checks = 0;
    int n_pass   = 0;

    pipeline_ctrl dut (
        .clk(clk), .rst(rst),
        .stall_req_if(stall_req_if), .stall_req_id(stall_req_id),
        .stall_req_ex(stall_req_ex), .stall_req_mem(stall_req_mem),
        .exc_valid(exc_valid), .exc_is_eret(exc_is_eret),
        .cp0_epc(cp0_epc), .cnt_clr(cnt_clr),
        .stall(stall), .flush(flush), .redirect_pc(redirect_pc),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    pipeline_ctrl #(.STALL_CNT_WIDTH(4), .FLUSH_CNT_WIDTH(2)) dut_small (
        .clk(clk), .rst(rst),
        .stall_req_if(stall_req_if), .stall_req_id(stall_req_id),
        .stall_req_ex(stall_req_ex), .stall_req_mem(stall_req_mem),
        .exc_valid(exc_valid), .exc_is_eret(exc_is_eret),
        .cp0_epc(cp0_epc), .cnt_clr(cnt_clr),
        .stall(stall_s), .flush(flush_s), .redirect_pc(redirect_pc_s),
        .stall_cnt(stall_cnt_s), .flush_cnt(flush_cnt_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 2 time units after each rising edge.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic idle_inputs();
        stall_req_if = 0; stall_req_id = 0; stall_req_ex = 0; stall_req_mem = 0;
        exc_valid = 0; exc_is_eret = 0; cnt_clr = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        cp0_epc = 32'h0;
        rst = 1'b0;
        #1;
        n_checks++;
        if (stall !== 6'b0 || flush !== 1'b0 || redirect_pc !== 32'h0)
            $display("FAIL reset_outputs: stall=%b flush=%b redirect=%h, required 0/0/0", stall, flush, redirect_pc);
        else n_pass++;
        tick(); tick();
        rst = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            n_checks++;
            if (stall !== 6'b0 || flush !== 1'b0)
                $display("FAIL idle_cycle%0d: stall=%b flush=%b, required 000000/0", i, stall, flush);
            else n_pass++;
        end
        n_checks++;
        if (stall_cnt !== 32'd0 || flush_cnt !== 16'd0)
            $display("FAIL idle_counters: stall_cnt=%0d flush_cnt=%0d, required 0/0", stall_cnt, flush_cnt);
        else n_pass++;
    endtask

    task automatic test_priority();
        logic [3:0] reqs [6];
        logic [5:0] exp  [6];
        reqs = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0101, 4'b1111};
        exp  = '{6'b000011, 6'b000111, 6'b001111, 6'b011111, 6'b001111, 6'b011111};
        for (int i = 0; i < 6; i++) begin
            {stall_req_mem, stall_req_ex, stall_req_id, stall_req_if} = reqs[i];
            #1;
            n_checks++;
            if (stall !== exp[i])
                $display("FAIL priority_%b: stall=%b, required %b", reqs[i], stall, exp[i]);
            else n_pass++;
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_stall_count();
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        stall_req_ex = 1'b1; stall_req_id = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_checks++;
            if (stall !== 6'b001111)
                $display("FAIL ex_id_stall%0d: stall=%b, required 001111", i, stall);
            else n_pass++;
            tick();
        end
        idle_inputs();
        #1;
        n_checks++;
        if (stall_cnt !== 32'd3 || stall !== 6'b0)
            $display("FAIL ex_id_count: stall_cnt=%0d stall=%b, required 3/000000", stall_cnt, stall);
        else n_pass++;
    endtask

    task automatic test_exc_idle();
        logic [31:0] sc0;
        logic [15:0] fc0;
        sc0 = stall_cnt; fc0 = flush_cnt;
        exc_valid = 1'b1; exc_is_eret = 1'b0; stall_req_id = 1'b1;
        #1;
        n_checks++;
        if (stall !== 6'b111111 || flush !== 1'b0)
            $display("FAIL exc_accept: stall=%b flush=%b, required 111111/0", stall, flush);
        else n_pass++;
        tick();
        stall_req_id = 1'b0;
        #1;
        n_checks++;
        if (flush !== 1'b1 || redirect_pc !== 32'hBFC00380 || stall !== 6'b0)
            $display("FAIL exc_flush: flush=%b redirect=%h stall=%b, required 1/bfc00380/000000", flush, redirect_pc, stall);
        else n_pass++;
        tick();
        exc_valid = 1'b0;
        #1;
        n_checks++;
        if (flush !== 1'b0 || redirect_pc !== 32'h0 || stall !== 6'b0)
            $display("FAIL exc_after: flush=%b redirect=%h stall=%b, required 0/0/000000", flush, redirect_pc, stall);
        else n_pass++;
        n_checks++;
        if (flush_cnt !== fc0 + 16'd1 || stall_cnt !== sc0 + 32'd1)
            $display("FAIL exc_counters: flush_cnt=%0d stall_cnt=%0d, required %0d/%0d", flush_cnt, stall_cnt, fc0 + 16'd1, sc0 + 32'd1);
        else n_pass++;
        tick();
    endtask

    task automatic test_eret_bus_busy();
        exc_valid = 1'b1; exc_is_eret = 1'b1; cp0_epc = 32'h80001234; stall_req_mem = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            n_checks++;
            if (stall !== 6'b111111 || flush !== 1'b0)
                $display("FAIL eret_wait%0d: stall=%b flush=%b, required 111111/0", i, stall, flush);
            else n_pass++;
            tick();
            exc_is_eret = 1'b0;
            cp0_epc = 32'hDEAD0000 + i;
            if (i == 3) stall_req_mem = 1'b0;
        end
        exc_valid = 1'b0;
        #1;
        n_checks++;
        if (flush !== 1'b1 || redirect_pc !== 32'h80001234 || stall !== 6'b0)
            $display("FAIL eret_flush: flush=%b redirect=%h stall=%b, required 1/80001234/000000", flush, redirect_pc, stall);
        else n_pass++;
        tick();
        n_checks++;
        if (flush !== 1'b0 || redirect_pc !== 32'h0)
            $display("FAIL eret_after: flush=%b redirect=%h, required 0/0", flush, redirect_pc);
        else n_pass++;
    endtask

    task automatic test_saturation();
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        stall_req_if = 1'b1;
        for (int i = 0; i < 14; i++) tick();
        n_checks++;
        if (stall_cnt_s !== 4'd14 || stall_s !== 6'b000011)
            $display("FAIL sat_preload: stall_cnt=%0d stall=%b, required 14/000011", stall_cnt_s, stall_s);
        else n_pass++;
        for (int i = 0; i < 4; i++) tick();
        n_checks++;
        if (stall_cnt_s !== 4'd15)
            $display("FAIL sat_hold: stall_cnt=%0d, required 15", stall_cnt_s);
        else n_pass++;
        n_checks++;
        if (stall_cnt !== 32'd18)
            $display("FAIL wide_count: stall_cnt=%0d, required 18", stall_cnt);
        else n_pass++;
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        stall_req_if = 1'b0;
        #1;
        n_checks++;
        if (stall_cnt_s !== 4'd0 || stall_cnt !== 32'd0 || flush_cnt !== 16'd0)
            $display("FAIL cnt_clr: small=%0d wide=%0d flush=%0d, required 0/0/0", stall_cnt_s, stall_cnt, flush_cnt);
        else n_pass++;
        for (int i = 0; i < 5; i++) begin
            exc_valid = 1'b1;
            tick();
            exc_valid = 1'b0;
            tick();
        end
        n_checks++;
        if (flush_cnt_s !== 2'd3 || flush_cnt !== 16'd5)
            $display("FAIL flush_sat: small=%0d wide=%0d, required 3/5", flush_cnt_s, flush_cnt);
        else n_pass++;
    endtask

    task automatic test_reset_in_wait();
        exc_valid = 1'b1; stall_req_mem = 1'b1;
        tick();
        exc_valid = 1'b0;
        #1;
        n_checks++;
        if (stall !== 6'b111111)
            $display("FAIL wait_entered: stall=%b, required 111111", stall);
        else n_pass++;
        rst = 1'b0;
        #1;
        n_checks++;
        if (stall !== 6'b0 || flush !== 1'b0 || redirect_pc !== 32'h0 || stall_cnt !== 32'd0 || flush_cnt !== 16'd0)
            $display("FAIL async_reset: stall=%b flush=%b redirect=%h sc=%0d fc=%0d, required all 0",
                     stall, flush, redirect_pc, stall_cnt, flush_cnt);
        else n_pass++;
        tick();
        stall_req_mem = 1'b0;
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_checks++;
            if (flush !== 1'b0 || stall !== 6'b0)
                $display("FAIL post_reset%0d: flush=%b stall=%b, required 0/000000", i, flush, stall);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_priority();
        test_stall_count();
        test_exc_idle();
        test_eret_bus_busy();
        test_saturation();
        test_reset_in_wait();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Central stall/flush sequencer for the six-stage pipeline (PC, IF, ID, EX, MEM, WB). It turns per-stage stall requests into the stall vector that drives every inter-stage pipeline register. Each register takes `stall[i]` as its current-stage stall and `stall[i+1]` as its next-stage stall. It also sequences exception and ERET flushes, holding the pipeline until outstanding bus transactions drain, and keeps saturating stall and flush counters for performance debug.

## Interface
- `ADDR_WIDTH`, 32, width of PC/redirect addresses
- `EXC_VECTOR`, 32'hBFC00380, redirect target for every non-ERET exception
- `STALL_CNT_WIDTH`, 32, width of stall-cycle counter
- `FLUSH_CNT_WIDTH`, 16, width of flush counter
- `clk`  in  1  pipeline clock; all state updates on rising edge
- `rst`  in  1  reset, asynchronous, active-low
- `stall_req_if`  in  1  IF waiting on instruction bus
- `stall_req_id`  in  1  ID load-use / operand hazard
- `stall_req_ex`  in  1  EX multicycle unit busy (mult/div)
- `stall_req_mem`  in  1  MEM waiting on data bus
- `exc_valid`  in  1  exception or ERET committed at MEM stage
- `exc_is_eret`  in  1  qualifies `exc_valid` as ERET
- `cp0_epc`  in  ADDR_WIDTH  current CP0 EPC, used for ERET
- `cnt_clr`  in  1  synchronous clear of both counters
- `stall`  out  6  bit0 PC, bit1 IF, bit2 ID, bit3 EX, bit4 MEM, bit5 WB
- `flush`  out  1  flush all pipeline registers this cycle
- `redirect_pc`  out  ADDR_WIDTH  PC target, valid only while `flush`=1
- `stall_cnt`  out  STALL_CNT_WIDTH  cycles with any `stall` bit set
- `flush_cnt`  out  FLUSH_CNT_WIDTH  number of flush cycles issued

## Operation
- The FSM has three states: RUN, EXC_WAIT, FLUSH. Reset enters RUN.
- RUN with no `exc_valid`: `stall` is decoded combinationally from the highest-indexed request.
  - `mem` -> 6'b011111
  - else `ex` -> 6'b001111
  - else `id` -> 6'b000111
  - else `if` -> 6'b000011
  - else 6'b000000
  - The stage just downstream of the highest stalled stage receives a bubble through the register rule (current stalled, next not).
- RUN with `exc_valid`=1:
  - Latch `exc_is_eret` and `cp0_epc`.
  - Drive `stall`=6'b111111 in that cycle.
  - Next state is EXC_WAIT if `stall_req_if|stall_req_mem`, else FLUSH.
- EXC_WAIT:
  - `stall`=6'b111111.
  - Stay while `stall_req_if|stall_req_mem`; go to FLUSH on the first cycle both are low.
  - `exc_valid`, `stall_req_id` and `stall_req_ex` are ignored.
- FLUSH (exactly one cycle):
  - `flush`=1, `stall`=0.
  - `redirect_pc` = latched EPC if latched ERET, else `EXC_VECTOR`.
  - Next state is RUN. `exc_valid` in this cycle is ignored.
- `redirect_pc` is 0 whenever `flush`=0.
- Counters:
  - `stall_cnt` +1 per cycle with `stall`!=0; `flush_cnt` +1 per FLUSH cycle.
  - Both saturate at all-ones and never wrap.
  - `cnt_clr` has priority over increment; clear takes effect next cycle.
- Reset mid-operation: any state returns to RUN immediately. The latched exception is discarded and the counters are cleared.

## Timing
- Reset values: `stall`=0, `flush`=0, `redirect_pc`=0, `stall_cnt`=0, `flush_cnt`=0, state RUN.
- In RUN, `stall` is combinational from the requests: same-cycle, zero latency.
- Exception with bus idle: `exc_valid` at cycle N -> all-stall at N -> `flush` at N+1 -> RUN at N+2.
- Exception with bus busy until cycle M (requests low at M): `flush` at M+1.
- `flush`, `redirect_pc` and the counters are registered or FSM-decoded and glitch-free.
- A stall request together with `exc_valid`: the exception wins and `stall`=6'b111111.
- `exc_is_eret` and `cp0_epc` are sampled only in the `exc_valid` acceptance cycle. Later changes do not affect `redirect_pc`.

## Test plan
- Reset release, no requests, 10 cycles -> `stall`=0 and `flush`=0 throughout; `stall_cnt`=0.
- `stall_req_ex` and `stall_req_id` both high for 3 cycles -> `stall`=6'b001111 for those 3 cycles; `stall_cnt`=3.
- `exc_valid`=1, `exc_is_eret`=0, bus idle at cycle N -> `stall`=6'b111111 at N; `flush`=1 with `redirect_pc`=32'hBFC00380 at N+1 only; `flush_cnt`=1.
- `exc_valid`+`exc_is_eret` with `cp0_epc`=32'h80001234 while `stall_req_mem` is high for 4 more cycles; change `cp0_epc` afterwards -> all-stall for 5 cycles, then `flush` with `redirect_pc`=32'h80001234.
- Preload `stall_cnt` near saturation, hold `stall_req_if` -> counter stops at all-ones. Then pulse `cnt_clr` -> 0 next cycle.
- Assert `rst` low during EXC_WAIT -> all outputs 0 asynchronously. After release, no `flush` is issued.
